// File: rtl/memoria_dp_param.sv
//------------------------------------------------------------------------------
// Module   : memoria_dp_param
// Brief    : True dual-port RAM, read-first, per-word written bits, 1- or 2-cycle
//            registered reads, same-address write collision detect and count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memoria_dp_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int RD_LAT     = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic                  re_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic                  collision,
    output logic [CNT_WIDTH-1:0]  coll_count
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [c_DEPTH-1:0]    r_written;

    logic                  w_coll;
    logic                  w_wr_b;
    logic [1:0]            w_re;
    logic [DATA_WIDTH-1:0] w_rd_word  [2];
    logic [1:0]            w_res_vld;
    logic [DATA_WIDTH-1:0] w_res_data [2];

    logic [DATA_WIDTH-1:0] r_q [2];
    logic [1:0]            r_valid;
    logic                  r_collision;
    logic [CNT_WIDTH-1:0]  r_coll_count;

    assign w_coll = we_a && we_b && (addr_a == addr_b);
    assign w_wr_b = we_b && !w_coll;
    assign w_re   = {re_b, re_a};

    // Writes during reset only touch the array; the cleared written bits hide them.
    always_ff @(posedge clk) begin
        if (we_a)   r_mem[addr_a] <= data_a;
        if (w_wr_b) r_mem[addr_b] <= data_b;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_written <= '0;
        end else begin
            if (we_a) r_written[addr_a] <= 1'b1;
            if (we_b) r_written[addr_b] <= 1'b1;
        end
    end

    // Combinational lookup of pre-edge contents gives read-first behaviour.
    assign w_rd_word[0] = r_written[addr_a] ? r_mem[addr_a] : '0;
    assign w_rd_word[1] = r_written[addr_b] ? r_mem[addr_b] : '0;

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_port
            if (RD_LAT == 2) begin : g_lat2
                logic                  r_p_vld;
                logic [DATA_WIDTH-1:0] r_p_data;

                always_ff @(posedge clk or negedge reset_L) begin
                    if (!reset_L) begin
                        r_p_vld  <= 1'b0;
                        r_p_data <= '0;
                    end else begin
                        r_p_vld <= w_re[p];
                        if (w_re[p]) r_p_data <= w_rd_word[p];
                    end
                end

                assign w_res_vld[p]  = r_p_vld;
                assign w_res_data[p] = r_p_data;
            end else begin : g_lat1
                assign w_res_vld[p]  = w_re[p];
                assign w_res_data[p] = w_rd_word[p];
            end

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    r_q[p]     <= '0;
                    r_valid[p] <= 1'b0;
                end else begin
                    r_valid[p] <= w_res_vld[p];
                    if (w_res_vld[p]) r_q[p] <= w_res_data[p];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_collision  <= 1'b0;
            r_coll_count <= '0;
        end else begin
            r_collision <= w_coll;
            if (w_coll && (r_coll_count != {CNT_WIDTH{1'b1}}))
                r_coll_count <= r_coll_count + 1'b1;
        end
    end

    assign q_a        = r_q[0];
    assign q_b        = r_q[1];
    assign valid_a    = r_valid[0];
    assign valid_b    = r_valid[1];
    assign collision  = r_collision;
    assign coll_count = r_coll_count;

endmodule

`default_nettype wire
